// File: rtl/jt10_adpcmb_seq.sv
// ADPCM-B sequencer: fetches sample bytes from ROM, splits them into nibbles and
// paces delivery to the decoder with a delta-N phase accumulator.
module jt10_adpcmb_seq #(
  parameter int AW  = 24,
  parameter int DNW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            start,
  input  logic            stop,
  input  logic            repeat_en,
  input  logic [AW-9:0]   start_addr,
  input  logic [AW-9:0]   end_addr,
  input  logic [DNW-1:0]  delta_n,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok,
  input  logic            clr_flag,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  output logic [3:0]      data,
  output logic            adv,
  output logic            chon,
  output logic            flag_end
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  ptr_reg, ptr_next;
  logic [DNW-1:0] acc_reg, acc_next;
  logic [7:0]     sample_reg, sample_next;
  logic           vld_reg, vld_next;
  logic           nib_reg, nib_next;
  logic           pend_reg, pend_next;
  logic           cs_reg, cs_next;
  logic [3:0]     data_reg, data_next;
  logic           adv_reg, adv_next;
  logic           chon_reg, chon_next;
  logic           flag_reg, flag_next;
  logic           fin_reg, fin_next;

  logic [DNW:0]   acc_sum;
  logic           carry;
  logic           fire;
  logic [AW-1:0]  start_ptr;
  logic [AW-1:0]  end_ptr;

  assign acc_sum   = {1'b0, acc_reg} + {1'b0, delta_n};
  assign carry     = acc_sum[DNW];
  assign start_ptr = {start_addr, 8'h00};
  assign end_ptr   = {end_addr, 8'hFF};

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    acc_next    = acc_reg;
    sample_next = sample_reg;
    vld_next    = vld_reg;
    nib_next    = nib_reg;
    pend_next   = pend_reg;
    cs_next     = cs_reg;
    data_next   = data_reg;
    adv_next    = 1'b0;
    chon_next   = chon_reg;
    flag_next   = flag_reg;
    fin_next    = fin_reg;
    fire        = 1'b0;
    if (cen) begin
      if (clr_flag) flag_next = 1'b0;
      case (state_reg)
        IDLE: begin
          chon_next = 1'b0;
          cs_next   = 1'b0;
          // fin_reg delays the flag by one cen so it lines up with chon falling
          if (fin_reg) begin
            flag_next = 1'b1;
            fin_next  = 1'b0;
          end
        end
        FETCH: begin
          if (cs_reg && rom_ok) begin
            sample_next = rom_data;
            vld_next    = 1'b1;
            nib_next    = 1'b0;
            cs_next     = 1'b0;
            chon_next   = 1'b1;
            state_next  = PLAY;
          end
        end
        PLAY: begin
          acc_next = acc_sum[DNW-1:0];
          fire     = carry || pend_reg;
          if (fire && vld_reg) begin
            data_next = nib_reg ? sample_reg[3:0] : sample_reg[7:4];
            adv_next  = 1'b1;
            nib_next  = ~nib_reg;
            pend_next = 1'b0;
            if (nib_reg) begin
              vld_next = 1'b0;
              if (ptr_reg == end_ptr) begin
                if (repeat_en) begin
                  ptr_next = start_ptr;
                  cs_next  = 1'b1;
                end else begin
                  state_next = IDLE;
                  fin_next   = 1'b1;
                end
              end else begin
                ptr_next = ptr_reg + 1'b1;
                cs_next  = 1'b1;
              end
            end
          end else if (carry) begin
            pend_next = 1'b1;
          end
          // the buffer is always empty while a fetch is outstanding
          if (cs_reg && rom_ok) begin
            sample_next = rom_data;
            vld_next    = 1'b1;
            nib_next    = 1'b0;
            cs_next     = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
      if (start) begin
        ptr_next   = start_ptr;
        acc_next   = '0;
        state_next = FETCH;
        cs_next    = 1'b1;
        vld_next   = 1'b0;
        pend_next  = 1'b0;
        nib_next   = 1'b0;
        fin_next   = 1'b0;
      end
      if (stop) begin
        state_next = IDLE;
        chon_next  = 1'b0;
        cs_next    = 1'b0;
        vld_next   = 1'b0;
        pend_next  = 1'b0;
        fin_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      acc_reg    <= '0;
      sample_reg <= '0;
      vld_reg    <= 1'b0;
      nib_reg    <= 1'b0;
      pend_reg   <= 1'b0;
      cs_reg     <= 1'b0;
      data_reg   <= '0;
      adv_reg    <= 1'b0;
      chon_reg   <= 1'b0;
      flag_reg   <= 1'b0;
      fin_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      acc_reg    <= acc_next;
      sample_reg <= sample_next;
      vld_reg    <= vld_next;
      nib_reg    <= nib_next;
      pend_reg   <= pend_next;
      cs_reg     <= cs_next;
      data_reg   <= data_next;
      adv_reg    <= adv_next;
      chon_reg   <= chon_next;
      flag_reg   <= flag_next;
      fin_reg    <= fin_next;
    end
  end

  assign rom_addr = ptr_reg;
  assign rom_cs   = cs_reg;
  assign data     = data_reg;
  assign adv      = adv_reg;
  assign chon     = chon_reg;
  assign flag_end = flag_reg;

endmodule

// File: tb/tb_jt10_adpcmb_seq.sv
// Scoreboard bench for jt10_adpcmb_seq: expected nibbles are queued when playback
// is started and popped on every adv strobe.
module tb_jt10_adpcmb_seq;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        start;
  logic        stop;
  logic        repeat_en;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [15:0] delta_n;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        clr_flag;
  logic [23:0] rom_addr;
  logic        rom_cs;
  logic [3:0]  data;
  logic        adv;
  logic        chon;
  logic        flag_end;

  int total = 0;
  int bad = 0;
  int rom_dly = 2;
  int rom_cnt = 0;
  logic [3:0] q[$];

  jt10_adpcmb_seq #(.AW(24), .DNW(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop),
    .repeat_en(repeat_en), .start_addr(start_addr), .end_addr(end_addr),
    .delta_n(delta_n), .rom_data(rom_data), .rom_ok(rom_ok), .clr_flag(clr_flag),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .data(data), .adv(adv),
    .chon(chon), .flag_end(flag_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data equals low address byte, valid rom_dly cycles into a request
  always @(posedge clk) begin
    if (!rom_cs) rom_cnt <= 0;
    else if (rom_cnt < 255) rom_cnt <= rom_cnt + 1;
  end
  assign rom_data = rom_addr[7:0];
  assign rom_ok   = rom_cs && (rom_cnt >= rom_dly);

  function automatic void push_bytes(input int first, input int nbytes);
    for (int b = first; b < first + nbytes; b++) begin
      logic [7:0] v;
      v = b[7:0];
      q.push_back(v[7:4]);
      q.push_back(v[3:0]);
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rom_addr, rom_cs, data, adv, chon, flag_end} !== 33'd0) begin
      bad++;
      $display("FAIL reset outputs got addr=%h cs=%b data=%h adv=%b chon=%b flag=%b required all 0",
               rom_addr, rom_cs, data, adv, chon, flag_end);
    end else $display("reset: outputs zero");
    rst = 1'b0;
  endtask

  task automatic test_single();
    int advs = 0;
    bit done = 0;
    logic [3:0] exp;
    q.delete();
    push_bytes(0, 256);
    start_addr = 16'd1; end_addr = 16'd1; delta_n = 16'h8000;
    repeat_en = 1'b0; rom_dly = 2; clr_flag = 1'b1;
    pulse_start();
    total++;
    if (rom_addr !== 24'h000100 || rom_cs !== 1'b1) begin
      bad++;
      $display("FAIL single_first_fetch got addr=%h cs=%b required 000100/1", rom_addr, rom_cs);
    end
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (adv === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL single_extra_adv got data=%h required no adv", data);
        end else begin
          exp = q.pop_front();
          if (data !== exp) begin
            bad++;
            $display("FAIL single_data n=%0d got=%h required=%h", advs, data, exp);
          end else $display("single adv n=%0d data=%h", advs, data);
          if (q.size() == 0) done = 1;
        end
        advs++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL single_timeout got advs=%0d required 512", advs);
    end
    @(negedge clk);
    total++;
    if (chon !== 1'b0 || flag_end !== 1'b1 || rom_cs !== 1'b0) begin
      bad++;
      $display("FAIL single_end got chon=%b flag=%b cs=%b required 0/1/0", chon, flag_end, rom_cs);
    end else $display("single end: chon=0 flag_end=1");
    @(negedge clk);
    total++;
    if (flag_end !== 1'b0) begin
      bad++;
      $display("FAIL single_clr_flag got flag=%b required 0", flag_end);
    end
    clr_flag = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (advs != 512 || chon !== 1'b0) begin
      bad++;
      $display("FAIL single_count got advs=%0d chon=%b required 512/0", advs, chon);
    end
  endtask

  task automatic test_repeat();
    int advs = 0;
    bit done = 0;
    bit flag_seen = 0;
    logic [3:0] exp;
    q.delete();
    push_bytes(0, 256);
    push_bytes(0, 4);
    start_addr = 16'd3; end_addr = 16'd3; delta_n = 16'h8000;
    repeat_en = 1'b1; rom_dly = 2;
    pulse_start();
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (flag_end === 1'b1) flag_seen = 1;
      if (adv === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL repeat_extra_adv got data=%h required no adv", data);
        end else begin
          exp = q.pop_front();
          if (data !== exp) begin
            bad++;
            $display("FAIL repeat_data n=%0d got=%h required=%h", advs, data, exp);
          end else $display("repeat adv n=%0d data=%h", advs, data);
          if (q.size() == 0) done = 1;
        end
        advs++;
        if (advs == 512) begin
          total++;
          if (rom_addr !== 24'h000300 || rom_cs !== 1'b1 || chon !== 1'b1) begin
            bad++;
            $display("FAIL repeat_wrap got addr=%h cs=%b chon=%b required 000300/1/1",
                     rom_addr, rom_cs, chon);
          end
        end
      end
    end
    total++;
    if (!done || flag_seen || chon !== 1'b1) begin
      bad++;
      $display("FAIL repeat_state got done=%b flag_seen=%b chon=%b required 1/0/1", done, flag_seen, chon);
    end
    pulse_stop();
  endtask

  task automatic test_underrun();
    int advs = 0;
    int since_ok = -1;
    bit done = 0;
    logic [3:0] exp;
    q.delete();
    push_bytes(0, 20);
    start_addr = 16'd5; end_addr = 16'd5; delta_n = 16'hFFFF;
    repeat_en = 1'b0; rom_dly = 8;
    pulse_start();
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (since_ok >= 0) since_ok++;
      if (since_ok == 1) begin
        total++;
        if (adv !== 1'b0) begin
          bad++;
          $display("FAIL underrun_early_adv got adv=%b required 0", adv);
        end
      end else if (since_ok == 2) begin
        total++;
        if (adv !== 1'b1) begin
          bad++;
          $display("FAIL underrun_pending_adv got adv=%b required 1", adv);
        end
        since_ok = -1;
      end
      if (adv === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL underrun_extra_adv got data=%h required no adv", data);
        end else begin
          exp = q.pop_front();
          if (data !== exp) begin
            bad++;
            $display("FAIL underrun_data n=%0d got=%h required=%h", advs, data, exp);
          end else $display("underrun adv n=%0d data=%h", advs, data);
          if (q.size() == 0) done = 1;
        end
        advs++;
      end
      if (rom_cs === 1'b1 && rom_ok === 1'b1 && chon === 1'b1) since_ok = 0;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL underrun_timeout got advs=%0d required 40", advs);
    end
    pulse_stop();
    rom_dly = 2;
  endtask

  task automatic test_stop_start();
    int advs = 0;
    bit done = 0;
    logic [3:0] exp;
    start_addr = 16'd1; end_addr = 16'd1; delta_n = 16'h8000; repeat_en = 1'b0;
    pulse_start();
    repeat (50) @(negedge clk);
    total++;
    if (chon !== 1'b1) begin
      bad++;
      $display("FAIL stop_pre_play got chon=%b required 1", chon);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    total++;
    if (chon !== 1'b0 || rom_cs !== 1'b0) begin
      bad++;
      $display("FAIL stop_idle got chon=%b cs=%b required 0/0", chon, rom_cs);
    end else $display("stop: idle");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (adv === 1'b1) advs++;
    end
    total++;
    if (advs != 0 || chon !== 1'b0 || flag_end !== 1'b0) begin
      bad++;
      $display("FAIL stop_quiet got advs=%0d chon=%b flag=%b required 0/0/0", advs, chon, flag_end);
    end
    advs = 0;
    q.delete();
    push_bytes(0, 3);
    start_addr = 16'd2; end_addr = 16'd2;
    pulse_start();
    total++;
    if (rom_addr !== 24'h000200 || rom_cs !== 1'b1) begin
      bad++;
      $display("FAIL restart_fetch got addr=%h cs=%b required 000200/1", rom_addr, rom_cs);
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (adv === 1'b1) begin
        total++;
        exp = q.pop_front();
        if (data !== exp) begin
          bad++;
          $display("FAIL restart_data n=%0d got=%h required=%h", advs, data, exp);
        end else $display("restart adv n=%0d data=%h", advs, data);
        advs++;
        if (q.size() == 0) done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL restart_timeout got advs=%0d required 6", advs);
    end
    pulse_stop();
  endtask

  task automatic test_rst_mid();
    int advs = 0;
    bit done = 0;
    logic [3:0] exp;
    start_addr = 16'd1; end_addr = 16'd1; delta_n = 16'h8000; repeat_en = 1'b0;
    pulse_start();
    repeat (30) @(negedge clk);
    cen = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({rom_addr, rom_cs, data, adv, chon, flag_end} !== 33'd0) begin
      bad++;
      $display("FAIL rst_mid got addr=%h cs=%b data=%h adv=%b chon=%b flag=%b required all 0",
               rom_addr, rom_cs, data, adv, chon, flag_end);
    end else $display("rst mid-play: outputs zero");
    rst = 1'b0; cen = 1'b1;
    q.delete();
    push_bytes(0, 4);
    pulse_start();
    total++;
    if (rom_addr !== 24'h000100 || rom_cs !== 1'b1) begin
      bad++;
      $display("FAIL rst_restart_fetch got addr=%h cs=%b required 000100/1", rom_addr, rom_cs);
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (adv === 1'b1) begin
        total++;
        exp = q.pop_front();
        if (data !== exp) begin
          bad++;
          $display("FAIL rst_restart_data n=%0d got=%h required=%h", advs, data, exp);
        end else $display("after rst adv n=%0d data=%h", advs, data);
        advs++;
        if (q.size() == 0) done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL rst_restart_timeout got advs=%0d required 8", advs);
    end
    pulse_stop();
  endtask

  task automatic test_delta_zero();
    int advs = 0;
    start_addr = 16'd1; end_addr = 16'd1; delta_n = 16'h0000; repeat_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (adv === 1'b1) advs++;
    end
    total++;
    if (advs != 0 || chon !== 1'b1) begin
      bad++;
      $display("FAIL delta_zero got advs=%0d chon=%b required 0/1", advs, chon);
    end else $display("delta_n=0: chon held, no adv");
    pulse_stop();
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    start_addr = '0; end_addr = '0; delta_n = '0; clr_flag = 1'b0;
    test_reset();
    test_single();
    test_repeat();
    test_underrun();
    test_stop_start();
    test_rst_mid();
    test_delta_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
